// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network output stage: decoder state
// encoding and an index-width helper that never returns zero.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } decoder_state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_count_decoder_sat_counter.sv
// Per-neuron spike counter: synchronous clear, increments that stick at
// the all-ones value instead of wrapping.
module sat_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;

    logic [COUNT_WIDTH-1:0] r_count;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX_COUNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/spike_count_decoder.sv
// Spike-count output decoder: counts spikes per neuron over a W-step window,
// scans the counts for the argmax winner and offers it over valid/ready.
module spike_count_decoder
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS  = 10,
    parameter int COUNT_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int IDX_WIDTH    = idx_width(NUM_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic [NUM_NEURONS-1:0]  spike_in,
    output logic                    net_rst,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [IDX_WIDTH-1:0]    winner_idx,
    output logic [COUNT_WIDTH-1:0]  winner_count,
    output logic                    no_spike,
    input  logic [IDX_WIDTH-1:0]    rd_sel,
    output logic [COUNT_WIDTH-1:0]  rd_count
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    decoder_state_t          r_state;
    decoder_state_t          w_next_state;
    logic [WINDOW_WIDTH-1:0] r_win_len;
    logic [WINDOW_WIDTH-1:0] r_ts;
    logic [IDX_WIDTH-1:0]    r_scan_idx;
    logic [IDX_WIDTH-1:0]    r_max_idx;
    logic [COUNT_WIDTH-1:0]  r_max_val;
    logic [IDX_WIDTH-1:0]    r_winner_idx;
    logic [COUNT_WIDTH-1:0]  r_winner_count;
    logic                    r_no_spike;
    logic                    r_net_rst;

    logic [COUNT_WIDTH-1:0]  w_count [NUM_NEURONS];
    logic                    w_accept;
    logic                    w_last_sample;
    logic                    w_last_scan;
    logic                    w_take;
    logic [COUNT_WIDTH-1:0]  w_cand;
    logic [COUNT_WIDTH-1:0]  w_rd_count;
    logic [COUNT_WIDTH-1:0]  w_new_max_val;
    logic [IDX_WIDTH-1:0]    w_new_max_idx;

    assign w_accept      = (r_state == IDLE) && start;
    assign w_last_sample = (r_ts == r_win_len - 1'b1);
    assign w_last_scan   = (r_scan_idx == LAST_IDX);

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
        sat_counter #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_accept),
            .inc   ((r_state == COUNT) && spike_in[gi]),
            .count (w_count[gi])
        );
    end

    // Selects never index past the last neuron, so rd_sel >= NUM_NEURONS reads 0.
    always_comb begin
        w_cand     = '0;
        w_rd_count = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (r_scan_idx == IDX_WIDTH'(i)) w_cand = w_count[i];
            if (rd_sel == IDX_WIDTH'(i))     w_rd_count = w_count[i];
        end
    end

    // Index 0 seeds the running max; later entries win only when strictly larger.
    assign w_take        = (r_scan_idx == '0) || (w_cand > r_max_val);
    assign w_new_max_val = w_take ? w_cand : r_max_val;
    assign w_new_max_idx = w_take ? r_scan_idx : r_max_idx;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = (window_len == '0) ? ARGMAX : COUNT;
            COUNT:   if (w_last_sample) w_next_state = ARGMAX;
            ARGMAX:  if (w_last_scan) w_next_state = DONE;
            DONE:    if (result_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_len      <= '0;
            r_ts           <= '0;
            r_scan_idx     <= '0;
            r_max_idx      <= '0;
            r_max_val      <= '0;
            r_winner_idx   <= '0;
            r_winner_count <= '0;
            r_no_spike     <= 1'b0;
            r_net_rst      <= 1'b0;
        end else begin
            r_net_rst <= w_accept;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_win_len  <= window_len;
                        r_ts       <= '0;
                        r_scan_idx <= '0;
                    end
                end
                COUNT: begin
                    r_ts <= r_ts + 1'b1;
                end
                ARGMAX: begin
                    r_max_val  <= w_new_max_val;
                    r_max_idx  <= w_new_max_idx;
                    r_scan_idx <= r_scan_idx + 1'b1;
                    if (w_last_scan) begin
                        r_winner_idx   <= w_new_max_idx;
                        r_winner_count <= w_new_max_val;
                        r_no_spike     <= (w_new_max_val == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign net_rst      = r_net_rst;
    assign busy         = (r_state == COUNT) || (r_state == ARGMAX);
    assign result_valid = (r_state == DONE);
    assign winner_idx   = r_winner_idx;
    assign winner_count = r_winner_count;
    assign no_spike     = r_no_spike;
    assign rd_count     = w_rd_count;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Randomised scoreboard bench for spike_count_decoder: a window-level model
// predicts counts and winners; a negedge monitor checks every result.
module tb_spike_count_decoder;

    localparam int N   = 5;
    localparam int CW  = 4;
    localparam int WW  = 8;
    localparam int IW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WW-1:0] window_len;
    logic [N-1:0]  spike_in;
    logic          net_rst;
    logic          busy;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] winner_idx;
    logic [CW-1:0] winner_count;
    logic          no_spike;
    logic [IW-1:0] rd_sel;
    logic [CW-1:0] rd_count;

    always #5 clk = ~clk;

    spike_count_decoder #(
        .NUM_NEURONS  (N),
        .COUNT_WIDTH  (CW),
        .WINDOW_WIDTH (WW),
        .IDX_WIDTH    (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .window_len   (window_len),
        .spike_in     (spike_in),
        .net_rst      (net_rst),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner_idx   (winner_idx),
        .winner_count (winner_count),
        .no_spike     (no_spike),
        .rd_sel       (rd_sel),
        .rd_count     (rd_count)
    );

    typedef struct {
        int idx;
        int cnt;
        int nospk;
        int k;
        int w;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_cur;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   net_rst_pulses = 0;
    int   exp_pulses = 0;
    int   exp_cnt [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && net_rst) net_rst_pulses <= net_rst_pulses + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: a spike adds one unless the count is already at full scale.
    task automatic model_step(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i] && exp_cnt[i] < SAT) exp_cnt[i]++;
    endtask

    function automatic int model_winner();
        int best = 0;
        for (int i = 1; i < N; i++)
            if (exp_cnt[i] > exp_cnt[best]) best = i;
        return best;
    endfunction

    // 0 random, 1 basic, 2 tie, 3 silent, 4 saturate, 5 edge (neuron 1 silent inside)
    function automatic logic [N-1:0] gen_vec(input int pat, input int t);
        logic [N-1:0] v = '0;
        case (pat)
            1: begin v[2] = 1'b1; v[1] = (t < 3); end
            2: begin v[1] = (t < 4); v[3] = (t < 4); end
            3: v = '0;
            4: v[0] = 1'b1;
            5: begin v = N'($urandom); v[1] = 1'b0; end
            default: v = N'($urandom) & N'($urandom | $urandom);
        endcase
        return v;
    endfunction

    task automatic readback(input string tag);
        int e;
        for (int s = 0; s < 8; s++) begin
            rd_sel = IW'(s);
            #1;
            if (s < N) e = exp_cnt[s];
            else       e = 0;
            check($sformatf("%s rd_count[%0d]", tag, s), rd_count, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " net_rst"}, net_rst, 0);
        check({tag, " winner_idx"}, winner_idx, 0);
        check({tag, " winner_count"}, winner_count, 0);
        check({tag, " no_spike"}, no_spike, 0);
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        readback(tag);
    endtask

    task automatic run_window(input int w, input int pat, input int hold);
        logic [N-1:0] v;
        exp_t         e;
        bit           seen;
        int           best;
        spike_in   = (pat == 5) ? N'(2) : N'($urandom);
        window_len = WW'(w);
        start      = 1'b1;
        @(posedge clk);
        #1;
        e.k   = cyc;
        start = 1'b0;
        exp_pulses++;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        for (int t = 0; t < w; t++) begin
            v        = gen_vec(pat, t);
            spike_in = v;
            model_step(v);
            if (t == 0) begin
                @(negedge clk);
                check("net_rst after start", net_rst, 1);
                check("busy after start", busy, 1);
            end
            @(posedge clk);
            #1;
            if (pat == 0) start = ($urandom_range(0, 3) == 0);
        end
        spike_in = (pat == 5) ? N'(2) : N'($urandom);
        if (w == 0) begin
            @(negedge clk);
            check("net_rst after start", net_rst, 1);
            check("busy after start", busy, 1);
        end
        start   = 1'b0;
        best    = model_winner();
        e.idx   = best;
        e.cnt   = exp_cnt[best];
        e.nospk = (exp_cnt[best] == 0) ? 1 : 0;
        e.w     = w;
        sb_q.push_back(e);

        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = result_valid;
        end
        check("result_valid within budget", int'(seen), 1);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            start    = 1'($urandom_range(0, 1));
            spike_in = N'($urandom);
        end
        start        = 1'b1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        result_ready = 1'b0;
        @(negedge clk);
        check("result_valid drop", result_valid, 0);
        check("start ignored in DONE", busy, 0);
        readback("idle");
    endtask

    task automatic reset_mid();
        window_len = WW'(8);
        spike_in   = N'($urandom);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_pulses++;
        for (int t = 0; t < 3; t++) begin
            spike_in = N'($urandom) | N'(1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid reset");
    endtask

    // Monitor: grabs the next expectation when a result appears, then checks it holds.
    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (result_valid && !prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected result", 1, 0);
                    end else begin
                        mon_cur = sb_q.pop_front();
                        check("winner_idx", winner_idx, mon_cur.idx);
                        check("winner_count", winner_count, mon_cur.cnt);
                        check("no_spike", no_spike, mon_cur.nospk);
                        check("result latency", cyc - mon_cur.k + 1, mon_cur.w + N + 1);
                    end
                end else if (result_valid) begin
                    check("held result",
                          int'({winner_idx, winner_count, no_spike}),
                          int'({IW'(mon_cur.idx), CW'(mon_cur.cnt), 1'(mon_cur.nospk)}));
                end
                prev = result_valid;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        window_len   = '0;
        spike_in     = '0;
        result_ready = 1'b0;
        rd_sel       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        run_window(10, 1, 7);
        run_window(5, 2, 0);
        run_window(5, 3, 0);
        reset_mid();
        run_window(7, 0, 2);
        run_window(20, 4, 1);
        run_window(0, 0, 0);
        run_window(6, 5, 0);
        for (int r = 0; r < 14; r++)
            run_window($urandom_range(0, 25), 0, $urandom_range(0, 3));

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard drained", sb_q.size(), 0);
        check("net_rst pulse count", net_rst_pulses, exp_pulses);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
